stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the BCD elapsed-time counter on the seven-segment stopwatch. It conditions two raw push-buttons and runs a start/stop/lap/clear state machine. From that state it drives the counter's clear and count-enable inputs. It also selects which BCD word, live elapsed time or a frozen lap snapshot, goes to the display path.

## Interface
- CLOCKSPEED, 12000000: system clock frequency in Hz; documentation only, not used in arithmetic.
- NUMCELLS, 4: number of BCD digits in `elapsed` and `display`.
- DEBOUNCE_CYCLES, 120000: number of consecutive cycles a synchronized button must hold a new level before it is accepted (10 ms at 12 MHz).
- clock  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- btn_ss  input  1  raw start/stop button, active-high, asynchronous to `clock`.
- btn_lr  input  1  raw lap/reset button, active-high, asynchronous to `clock`.
- elapsed  input  4*NUMCELLS  live BCD time from the counter; digit 0 is in [3:0].
- timer_rst  output  1  counter clear; high holds the counter at zero.
- timer_run  output  1  counter count-enable.
- display  output  4*NUMCELLS  BCD word sent to the segment driver.
- state  output  2  current state: CLEAR=00, RUN=01, STOP=10, LAP=11.
- lap_active  output  1  high while `display` shows the frozen lap value.

## Operation
- Each button goes through a 2-flop synchronizer, then a debouncer.
- Debouncer: a per-button counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
  - The counter resets whenever the synchronized level equals the accepted level.
  - When the synchronized level differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles, the accepted level flips.
  - A 0->1 flip of the accepted level produces a 1-cycle press pulse. Releases produce no event.
- State transitions (ss = start/stop pulse, lr = lap/reset pulse):
  - CLEAR: ss -> RUN.
  - RUN: ss -> STOP. lr -> LAP, and `elapsed` is captured into the lap register on the same edge.
  - LAP: lr -> RUN (release the frozen display). ss -> STOP (counter halts; display returns to live).
  - STOP: ss -> RUN. lr -> CLEAR.
  - Any pulse not listed above is ignored.
- If ss and lr pulse in the same cycle, ss wins and lr is discarded.
- Output decode, registered from the next-state value so outputs change on the same edge as `state`:
  - timer_rst = 1 only in CLEAR.
  - timer_run = 1 in RUN and LAP.
  - lap_active = 1 only in LAP.
- `display` is a registered mux: the lap register while in LAP, otherwise `elapsed`. `elapsed` is passed through bit-exact, with no BCD correction applied.

## Timing
- Reset values:
  - state = CLEAR, timer_rst = 1, timer_run = 0, lap_active = 0.
  - display = 0, lap register = 0.
  - Debounce counters = 0, accepted levels = 0, synchronizers = 0.
- Raw edge to press pulse: 2 cycles of synchronization + DEBOUNCE_CYCLES + 1 cycles.
- Press pulse to new `state` and outputs: 1 cycle.
- `display` follows `elapsed` with 1 cycle of latency.
- The lap snapshot equals the `elapsed` value present in the cycle the lr pulse is high.
- rst asserted mid-operation: every register returns to its reset value immediately. A button held high through reset produces no press pulse until it has been released and pressed again.
- Bounce shorter than DEBOUNCE_CYCLES produces no event. Holding a button produces exactly one event.

## Configuration
- STOPWATCH_LAP_EN defined: LAP state, lap register and `lap_active` behave as specified above.
- STOPWATCH_LAP_EN undefined:
  - The lap register is not built and the LAP encoding is unreachable.
  - lr in RUN is ignored; lr in STOP still goes to CLEAR.
  - lap_active is tied to 0 and `display` always follows `elapsed` with 1 cycle of latency.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUMCELLS=4.
- Reset, then hold btn_ss high for 10 cycles -> exactly one press; state 00->01 at cycle 2+4+1+1 after the rise; timer_rst 1->0 and timer_run 0->1 on that same edge.
- In RUN, toggle btn_ss high/low every 2 cycles for 20 cycles, then hold it low -> no state change.
- In RUN with elapsed=16'h0123, press lr; then drive elapsed=16'h0456 -> state=11, display stays 16'h0123, lap_active=1, timer_run=1; a second lr -> state=01 and display=16'h0456 one cycle later.
- In RUN, ss and lr pulse in the same cycle -> state=10, no lap capture; then lr -> state=00 and timer_rst=1.
- Assert rst for 1 cycle while in LAP with btn_lr held high -> all outputs at reset values immediately; no lr event until btn_lr falls and rises again.
- With STOPWATCH_LAP_EN undefined, press lr in RUN -> state stays 01 and lap_active stays 0.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch control sequencer and its surroundings.
// The DUT side uses the slave modport; the stimulus/counter side uses master.
interface stopwatch_ctrl_if #(
  parameter int NUMCELLS = 4
);
  logic                    btn_ss;
  logic                    btn_lr;
  logic [4*NUMCELLS-1:0]   elapsed;
  logic                    timer_rst;
  logic                    timer_run;
  logic [4*NUMCELLS-1:0]   display;
  logic [1:0]              state;
  logic                    lap_active;

  modport master (
    output btn_ss, btn_lr, elapsed,
    input  timer_rst, timer_run, display, state, lap_active
  );

  modport slave (
    input  btn_ss, btn_lr, elapsed,
    output timer_rst, timer_run, display, state, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/stop/lap/clear sequencer with button conditioning and display select.
// Define STOPWATCH_LAP_EN to build the LAP state, lap register and lap_active output.
module stopwatch_ctrl #(
  parameter int CLOCKSPEED      = 12000000,
  parameter int NUMCELLS        = 4,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic             clock,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'b00,
    S_RUN   = 2'b01,
    S_STOP  = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  logic [1:0]    raw_s;
  logic [1:0]    meta_r;
  logic [1:0]    sync_r;
  logic [1:0]    acc_r;
  logic [1:0]    acc_d_r;
  logic [1:0]    armed_r;
  logic [1:0]    press_r;
  logic [1:0]    init_r;
  logic [CW-1:0] cnt_r [2];
  logic          ss_s;
  logic          lr_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          timer_rst_nxt_s;
  logic          timer_run_nxt_s;
  logic          lap_nxt_s;
  logic          timer_rst_r;
  logic          timer_run_r;
  logic          lap_active_r;
  logic [4*NUMCELLS-1:0] display_r;

  assign raw_s = {sw.btn_lr, sw.btn_ss};
  assign ss_s  = press_r[0];
  assign lr_s  = press_r[1];

  // Synchronize, debounce and edge-detect both buttons. A button is armed only
  // once it has been seen released after reset, so a level held through reset
  // cannot produce a press.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      meta_r  <= 2'b00;
      sync_r  <= 2'b00;
      acc_r   <= 2'b00;
      acc_d_r <= 2'b00;
      armed_r <= 2'b00;
      press_r <= 2'b00;
      init_r  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      meta_r  <= raw_s;
      sync_r  <= meta_r;
      init_r  <= {init_r[0], 1'b1};
      acc_d_r <= acc_r;
      press_r <= acc_r & ~acc_d_r & armed_r;
      for (int i = 0; i < 2; i++) begin
        if (init_r[1] && !sync_r[i]) begin
          armed_r[i] <= 1'b1;
        end else begin
          armed_r[i] <= armed_r[i];
        end
        if (sync_r[i] == acc_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          acc_r[i] <= sync_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r <= S_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start/stop takes priority over lap/reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_CLEAR: begin
        if (ss_s) state_nxt_s = S_RUN;
        else      state_nxt_s = S_CLEAR;
      end
      S_RUN: begin
        if (ss_s) state_nxt_s = S_STOP;
`ifdef STOPWATCH_LAP_EN
        else if (lr_s) state_nxt_s = S_LAP;
`endif
        else      state_nxt_s = S_RUN;
      end
      S_STOP: begin
        if (ss_s)      state_nxt_s = S_RUN;
        else if (lr_s) state_nxt_s = S_CLEAR;
        else           state_nxt_s = S_STOP;
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        if (ss_s)      state_nxt_s = S_STOP;
        else if (lr_s) state_nxt_s = S_RUN;
        else           state_nxt_s = S_LAP;
      end
`endif
      default: state_nxt_s = S_CLEAR;
    endcase
  end

  // Output decode from the next state so outputs move with state.
  always_comb begin
    timer_rst_nxt_s = 1'b1;
    timer_run_nxt_s = 1'b0;
    case (state_nxt_s)
      S_CLEAR: begin timer_rst_nxt_s = 1'b1; timer_run_nxt_s = 1'b0; end
      S_RUN:   begin timer_rst_nxt_s = 1'b0; timer_run_nxt_s = 1'b1; end
      S_STOP:  begin timer_rst_nxt_s = 1'b0; timer_run_nxt_s = 1'b0; end
`ifdef STOPWATCH_LAP_EN
      S_LAP:   begin timer_rst_nxt_s = 1'b0; timer_run_nxt_s = 1'b1; end
`endif
      default: begin timer_rst_nxt_s = 1'b1; timer_run_nxt_s = 1'b0; end
    endcase
`ifdef STOPWATCH_LAP_EN
    lap_nxt_s = (state_nxt_s == S_LAP);
`else
    lap_nxt_s = 1'b0;
`endif
  end

  // Registered control outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      timer_rst_r  <= 1'b1;
      timer_run_r  <= 1'b0;
      lap_active_r <= 1'b0;
    end else begin
      timer_rst_r  <= timer_rst_nxt_s;
      timer_run_r  <= timer_run_nxt_s;
      lap_active_r <= lap_nxt_s;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [4*NUMCELLS-1:0] lap_r;

  // Lap snapshot and display select; the snapshot is taken only on a lone lr in RUN.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lap_r     <= '0;
      display_r <= '0;
    end else begin
      if (state_r == S_RUN && lr_s && !ss_s) begin
        lap_r <= sw.elapsed;
      end else begin
        lap_r <= lap_r;
      end
      display_r <= (state_r == S_LAP) ? lap_r : sw.elapsed;
    end
  end
`else
  // Display follows the live counter value.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      display_r <= '0;
    end else begin
      display_r <= sw.elapsed;
    end
  end
`endif

  assign sw.state      = state_r;
  assign sw.timer_rst  = timer_rst_r;
  assign sw.timer_run  = timer_run_r;
  assign sw.lap_active = lap_active_r;
  assign sw.display    = display_r;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, NUMCELLS=4.
// Expectations for lr in RUN depend on STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;
  localparam int NUMCELLS = 4;
  localparam int DEB      = 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  stopwatch_ctrl_if #(.NUMCELLS(NUMCELLS)) sw ();

  stopwatch_ctrl #(
    .CLOCKSPEED      (12000000),
    .NUMCELLS        (NUMCELLS),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .sw    (sw.slave)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Press for 8 cycles (state updates on the 8th edge), then release for 8.
  task automatic press(input bit lr);
    if (lr) sw.btn_lr = 1'b1;
    else    sw.btn_ss = 1'b1;
    step(8);
    sw.btn_lr = 1'b0;
    sw.btn_ss = 1'b0;
    step(8);
  endtask

  initial begin
    sw.btn_ss  = 1'b0;
    sw.btn_lr  = 1'b0;
    sw.elapsed = 16'h0000;
    step(2);
    check("rst_state",     16'(sw.state),      16'h0000);
    check("rst_timer_rst", 16'(sw.timer_rst),  16'h0001);
    check("rst_timer_run", 16'(sw.timer_run),  16'h0000);
    check("rst_lap",       16'(sw.lap_active), 16'h0000);
    check("rst_display",   sw.display,         16'h0000);
    rst = 1'b0;
    step(4);

    // Held ss: state changes on edge 2+4+1+1 after the rise.
    sw.btn_ss = 1'b1;
    step(7);
    check("ss_lat_state7",  16'(sw.state),     16'h0000);
    check("ss_lat_trst7",   16'(sw.timer_rst), 16'h0001);
    step(1);
    check("ss_lat_state8",  16'(sw.state),     16'h0001);
    check("ss_lat_trst8",   16'(sw.timer_rst), 16'h0000);
    check("ss_lat_trun8",   16'(sw.timer_run), 16'h0001);
    step(2);
    sw.btn_ss = 1'b0;
    step(10);
    check("ss_hold_once",   16'(sw.state),     16'h0001);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      sw.btn_ss = ~sw.btn_ss;
      step(2);
      check("bounce_state", 16'(sw.state), 16'h0001);
    end
    step(10);
    check("bounce_final", 16'(sw.state), 16'h0001);

    // Bit-exact pass-through with one cycle of latency.
    sw.elapsed = 16'hABCD;
    #1;
    check("pass_before", sw.display, 16'h0000);
    step(1);
    check("pass_after",  sw.display, 16'hABCD);

    // Lap capture and release.
    sw.elapsed = 16'h0123;
    step(1);
    sw.btn_lr = 1'b1;
    step(8);
    sw.elapsed = 16'h0456;
    sw.btn_lr  = 1'b0;
    step(8);
`ifdef STOPWATCH_LAP_EN
    check("lap_state",   16'(sw.state),      16'h0003);
    check("lap_display", sw.display,         16'h0123);
    check("lap_active",  16'(sw.lap_active), 16'h0001);
    check("lap_run",     16'(sw.timer_run),  16'h0001);
    sw.btn_lr = 1'b1;
    step(8);
    check("unlap_state",  16'(sw.state), 16'h0001);
    check("unlap_disp0",  sw.display,    16'h0123);
    step(1);
    check("unlap_disp1",  sw.display,    16'h0456);
    sw.btn_lr = 1'b0;
    step(8);
    check("unlap_active", 16'(sw.lap_active), 16'h0000);
`else
    check("nolap_state",   16'(sw.state),      16'h0001);
    check("nolap_active",  16'(sw.lap_active), 16'h0000);
    check("nolap_display", sw.display,         16'h0456);
    check("nolap_run",     16'(sw.timer_run),  16'h0001);
`endif

    // Simultaneous ss and lr in RUN: ss wins.
    sw.elapsed = 16'h0789;
    sw.btn_ss  = 1'b1;
    sw.btn_lr  = 1'b1;
    step(8);
    check("both_state", 16'(sw.state),      16'h0002);
    check("both_run",   16'(sw.timer_run),  16'h0000);
    check("both_trst",  16'(sw.timer_rst),  16'h0000);
    check("both_lap",   16'(sw.lap_active), 16'h0000);
    sw.btn_ss = 1'b0;
    sw.btn_lr = 1'b0;
    step(8);
    check("stop_display", sw.display, 16'h0789);
    press(1'b1);
    check("clr_state", 16'(sw.state),     16'h0000);
    check("clr_trst",  16'(sw.timer_rst), 16'h0001);
    check("clr_trun",  16'(sw.timer_run), 16'h0000);

    // Reset mid-operation with buttons held.
    press(1'b0);
    check("rerun_state", 16'(sw.state), 16'h0001);
    sw.btn_lr = 1'b1;
    step(8);
`ifdef STOPWATCH_LAP_EN
    check("pre_rst_state", 16'(sw.state), 16'h0003);
`else
    check("pre_rst_state", 16'(sw.state), 16'h0001);
`endif
    rst       = 1'b1;
    sw.btn_ss = 1'b1;
    #1;
    check("mid_rst_state",   16'(sw.state),      16'h0000);
    check("mid_rst_trst",    16'(sw.timer_rst),  16'h0001);
    check("mid_rst_trun",    16'(sw.timer_run),  16'h0000);
    check("mid_rst_lap",     16'(sw.lap_active), 16'h0000);
    check("mid_rst_display", sw.display,         16'h0000);
    step(1);
    rst = 1'b0;
    step(20);
    check("held_no_event",  16'(sw.state),     16'h0000);
    check("held_trst",      16'(sw.timer_rst), 16'h0001);
    sw.btn_ss = 1'b0;
    sw.btn_lr = 1'b0;
    step(10);
    press(1'b0);
    check("repress_run",  16'(sw.state), 16'h0001);
    press(1'b0);
    check("repress_stop", 16'(sw.state), 16'h0002);
    press(1'b1);
    check("repress_clr",  16'(sw.state), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
